qupls4_backout_walker: RTL and testbench
========================================

QUPLS4_BACKOUT_WALKER -- requirements
Module: Qupls4_backout_walker

Consumer of the branch-unit backout pulse. On backout, walks the ROB entries younger than the backing-out branch, youngest first. For each entry it restores the register alias table (RAT) mapping and releases the newly allocated physical register.

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ROB_ENTRIES, 16, ROB depth; SHALL be a power of two.
- AREG_W, 7, architectural register index width.
- PREG_W, 9, physical register index width.
- RW = $clog2(ROB_ENTRIES).

REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk, in, 1, sole clock; all state on rising edge.
- rst, in, 1, asynchronous, active-high reset.
- backout, in, 1, single-cycle request from the branch unit.
- backout_rob, in, RW, ROB index of the backing-out branch.
- rob_tail, in, RW, current ROB tail (next free slot), sampled with backout.
- rob_rd_en, out, 1, ROB read strobe.
- rob_rd_addr, out, RW, ROB index being read.
- rob_has_dest, in, 1, entry allocated a destination; valid the cycle after rob_rd_en.
- rob_areg, in, AREG_W, architectural destination; same timing.
- rob_old_preg, in, PREG_W, previous mapping; same timing.
- rob_new_preg, in, PREG_W, mapping allocated by the entry; same timing.
- rat_wr_en, out, 1, RAT restore write strobe.
- rat_wr_areg, out, AREG_W, RAT index to restore.
- rat_wr_preg, out, PREG_W, value to restore.
- free_en, out, 1, free-list release strobe.
- free_preg, out, PREG_W, physical register released.
- busy, out, 1, walk in progress.
- stall_rename, out, 1, rename stall.
- done, out, 1, single-cycle completion pulse.
- new_tail, out, RW, tail after backout; valid while done=1.
- backout_lost, out, 1, sticky: a backout arrived while not IDLE.

Function
REQ-003 The state machine SHALL have exactly four states: IDLE, WALK, DRAIN, DONE.

REQ-004 In IDLE, backout=1 SHALL latch backout_rob and compute count = (rob_tail - backout_rob - 1) mod ROB_ENTRIES in RW-bit wrap-around arithmetic.
- If count != 0: next state SHALL be WALK, with read pointer = rob_tail - 1 (mod).
- If count == 0: next state SHALL be DONE.

REQ-005 In WALK, each cycle the block SHALL:
- assert rob_rd_en with rob_rd_addr = read pointer;
- decrement the read pointer (mod ROB_ENTRIES);
- decrement the remaining count.
When the count reaches zero after issuing the last read, next state SHALL be DRAIN.

REQ-006 The ROB read data for each strobe SHALL be registered into the RAT/free outputs one cycle after it is presented: read in cycle k gives outputs in cycle k+2.

REQ-007 For a returned entry with rob_has_dest=1, in the same cycle:
- rat_wr_en=1, rat_wr_areg=rob_areg, rat_wr_preg=rob_old_preg;
- free_en=1, free_preg=rob_new_preg.

REQ-008 For a returned entry with rob_has_dest=0, rat_wr_en and free_en SHALL be 0 in that cycle; the walk SHALL continue.

REQ-009 DRAIN SHALL last until the final entry's writes have issued, then transition to DONE.

REQ-010 DONE SHALL last one cycle, then return to IDLE. In DONE: done=1 and new_tail = latched backout_rob + 1 (mod).

REQ-011 Timing for count N>0, with backout sampled in cycle 0:
- reads in cycles 1..N;
- writes in cycles 3..N+2;
- done in cycle N+3.
For N=0: done in cycle 1 and no reads.

REQ-012 busy SHALL be 1 whenever state != IDLE.

REQ-013 stall_rename SHALL be the combinational OR of busy and backout.

REQ-014 A backout received while state != IDLE SHALL be ignored and SHALL set backout_lost; backout_lost SHALL clear only on reset.

REQ-015 rat_wr_en, free_en, rob_rd_en and done SHALL each be 0 in every cycle not stated above.

REQ-016 Walk order SHALL be strictly youngest to oldest, so the oldest entry's old mapping is the final RAT value for each register.

Reset
REQ-017 Asserting rst SHALL immediately force:
- state = IDLE;
- all strobes, busy, done and backout_lost = 0;
- rob_rd_addr, new_tail, rat_wr_areg, rat_wr_preg, free_preg = 0.

REQ-018 Reset mid-walk SHALL abandon the walk with no further writes. After reset deasserts, the block SHALL accept a new backout on the first clock edge.

Verification
REQ-019 Basic walk: backout_rob=3, rob_tail=7, entries 6,5,4 all has_dest → rd_addr 6,5,4 in cycles 1-3; RAT/free writes for 6,5,4 in cycles 3-5; done=1 and new_tail=4 in cycle 6.

REQ-020 Wrap: backout_rob=14, rob_tail=2 → reads 1,0,15; done in cycle 6 with new_tail=15.

REQ-021 Empty: backout_rob=5, rob_tail=6 → no rob_rd_en; done in cycle 1 with new_tail=6; busy high for cycle 1 only.

REQ-022 Mixed: backout_rob=0, rob_tail=4, entry 2 has_dest=0 → writes only for entries 3 and 1, in cycles 3 and 5; cycle 4 has no writes.

REQ-023 Collision: second backout in cycle 2 of a walk → ignored, walk unchanged, backout_lost=1 thereafter.

REQ-024 Reset: rst asserted in cycle 2 of REQ-019 → outputs 0 asynchronously, no writes afterwards, and a fresh backout after release is handled normally.

Source files
------------

// File: rtl/qupls4_backout_walker.sv
// rtl/qupls4_backout_walker.sv - ROB backout walker restoring RAT mappings and freeing physical registers
//
// Purpose: on a branch backout, walks the ROB entries younger than the branch,
// youngest first, restoring each entry's old RAT mapping and releasing the
// physical register it allocated.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   backout, backout_rob     backout request and ROB index of the branch
//   rob_tail                 ROB tail sampled with backout
//   rob_rd_en, rob_rd_addr   ROB read port (data returns one cycle later)
//   rob_has_dest, rob_areg,
//   rob_old_preg, rob_new_preg  ROB read data
//   rat_wr_en/areg/preg      RAT restore write
//   free_en, free_preg       free-list release
//   busy, stall_rename       walk in progress / rename stall
//   done, new_tail           completion pulse and post-backout tail
//   backout_lost             sticky: backout arrived while not idle
module qupls4_backout_walker #(
  parameter int ROB_ENTRIES = 16,
  parameter int AREG_W      = 7,
  parameter int PREG_W      = 9,
  localparam int RW         = $clog2(ROB_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              backout,
  input  logic [RW-1:0]     backout_rob,
  input  logic [RW-1:0]     rob_tail,
  output logic              rob_rd_en,
  output logic [RW-1:0]     rob_rd_addr,
  input  logic              rob_has_dest,
  input  logic [AREG_W-1:0] rob_areg,
  input  logic [PREG_W-1:0] rob_old_preg,
  input  logic [PREG_W-1:0] rob_new_preg,
  output logic              rat_wr_en,
  output logic [AREG_W-1:0] rat_wr_areg,
  output logic [PREG_W-1:0] rat_wr_preg,
  output logic              free_en,
  output logic [PREG_W-1:0] free_preg,
  output logic              busy,
  output logic              stall_rename,
  output logic              done,
  output logic [RW-1:0]     new_tail,
  output logic              backout_lost
);

  typedef enum logic [1:0] {IDLE, WALK, DRAIN, DONE} state_t;

  state_t      state, next_state;
  logic [RW-1:0] rd_ptr;
  logic [RW-1:0] remaining;
  logic [RW-1:0] bo_rob;
  logic [RW-1:0] count_in;
  // High in the cycle the ROB presents data for a read issued last cycle.
  logic        rd_vld;
  logic        wr_en_q;

  // Number of entries strictly younger than the branch, modulo ROB depth.
  assign count_in = rob_tail - backout_rob - RW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (backout) next_state = (count_in != '0) ? WALK : DONE;
      WALK:  if (remaining == RW'(1)) next_state = DRAIN;
      // Leave once the last read's data has been consumed; its writes
      // are on the outputs in this final DRAIN cycle.
      DRAIN: if (!rd_vld) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      remaining    <= '0;
      bo_rob       <= '0;
      rd_vld       <= 1'b0;
      wr_en_q      <= 1'b0;
      rat_wr_areg  <= '0;
      rat_wr_preg  <= '0;
      free_preg    <= '0;
      backout_lost <= 1'b0;
    end else begin
      if (state == IDLE && backout) begin
        bo_rob    <= backout_rob;
        remaining <= count_in;
        rd_ptr    <= rob_tail - RW'(1);
      end else if (state == WALK) begin
        rd_ptr    <= rd_ptr - RW'(1);
        remaining <= remaining - RW'(1);
      end

      rd_vld  <= (state == WALK);
      wr_en_q <= rd_vld && rob_has_dest;
      if (rd_vld && rob_has_dest) begin
        rat_wr_areg <= rob_areg;
        rat_wr_preg <= rob_old_preg;
        free_preg   <= rob_new_preg;
      end

      if (backout && state != IDLE) backout_lost <= 1'b1;
    end
  end

  assign rob_rd_en    = (state == WALK);
  assign rob_rd_addr  = rd_ptr;
  assign rat_wr_en    = wr_en_q;
  assign free_en      = wr_en_q;
  assign busy         = (state != IDLE);
  assign stall_rename = busy | backout;
  assign done         = (state == DONE);
  assign new_tail     = done ? (bo_rob + RW'(1)) : '0;

endmodule

// File: tb/tb_qupls4_backout_walker.sv
// tb/tb_qupls4_backout_walker.sv - scoreboard testbench for qupls4_backout_walker
module tb_qupls4_backout_walker;

  localparam int N_ROB = 16;
  localparam int AW    = 7;
  localparam int PW    = 9;
  localparam int RW    = 4;
  localparam int NEVER = 32'h7fffffff;

  logic          clk = 0;
  logic          rst = 1;
  logic          backout = 0;
  logic [RW-1:0] backout_rob = 0;
  logic [RW-1:0] rob_tail = 0;
  logic          rob_rd_en;
  logic [RW-1:0] rob_rd_addr;
  logic          rob_has_dest = 0;
  logic [AW-1:0] rob_areg = 0;
  logic [PW-1:0] rob_old_preg = 0;
  logic [PW-1:0] rob_new_preg = 0;
  logic          rat_wr_en;
  logic [AW-1:0] rat_wr_areg;
  logic [PW-1:0] rat_wr_preg;
  logic          free_en;
  logic [PW-1:0] free_preg;
  logic          busy;
  logic          stall_rename;
  logic          done;
  logic [RW-1:0] new_tail;
  logic          backout_lost;

  qupls4_backout_walker #(.ROB_ENTRIES(N_ROB), .AREG_W(AW), .PREG_W(PW)) dut (
    .clk(clk), .rst(rst), .backout(backout), .backout_rob(backout_rob),
    .rob_tail(rob_tail), .rob_rd_en(rob_rd_en), .rob_rd_addr(rob_rd_addr),
    .rob_has_dest(rob_has_dest), .rob_areg(rob_areg), .rob_old_preg(rob_old_preg),
    .rob_new_preg(rob_new_preg), .rat_wr_en(rat_wr_en), .rat_wr_areg(rat_wr_areg),
    .rat_wr_preg(rat_wr_preg), .free_en(free_en), .free_preg(free_preg),
    .busy(busy), .stall_rename(stall_rename), .done(done), .new_tail(new_tail),
    .backout_lost(backout_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROB contents
  logic          m_has[N_ROB];
  logic [AW-1:0] m_areg[N_ROB];
  logic [PW-1:0] m_old[N_ROB];
  logic [PW-1:0] m_new[N_ROB];

  // ROB read port: data the cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (rob_rd_en) begin
      rob_has_dest <= m_has[rob_rd_addr];
      rob_areg     <= m_areg[rob_rd_addr];
      rob_old_preg <= m_old[rob_rd_addr];
      rob_new_preg <= m_new[rob_rd_addr];
    end else begin
      rob_has_dest <= 1'($urandom);
      rob_areg     <= AW'($urandom);
      rob_old_preg <= PW'($urandom);
      rob_new_preg <= PW'($urandom);
    end
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] areg;
    logic [PW-1:0] a;
    logic [PW-1:0] b;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t dn_q[$];

  int busy_s = 0;
  int busy_e = -1;
  int lost_cyc = NEVER;
  int cmp_n = 0;
  int err_n = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic flush_late(inout ev_t q[$], input string name);
    while (q.size() > 0 && q[0].cyc < cyc) begin
      cmp_n++; err_n++;
      $display("FAIL %s missing cycle=%0d expected_at=%0d", name, cyc, q[0].cyc);
      void'(q.pop_front());
    end
  endtask

  // Monitor: compares every cycle at the falling edge.
  always @(negedge clk) begin
    bit eb;
    ev_t e;
    if (cyc > 0) begin
      eb = !rst && cyc >= busy_s && cyc <= busy_e;
      chk("busy", busy, eb);
      chk("stall_rename", stall_rename, eb | backout);
      chk("backout_lost", backout_lost, !rst && cyc >= lost_cyc);
      chk("free_en_eq_rat_wr_en", free_en, rat_wr_en);
      flush_late(rd_q, "read");
      flush_late(wr_q, "write");
      flush_late(dn_q, "done");
      if (rob_rd_en) begin
        if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          e = rd_q.pop_front();
          chk("read_cycle", cyc, e.cyc);
          chk("rob_rd_addr", rob_rd_addr, e.a);
        end
      end
      if (rat_wr_en || free_en) begin
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = wr_q.pop_front();
          chk("write_cycle", cyc, e.cyc);
          chk("rat_wr_areg", rat_wr_areg, e.areg);
          chk("rat_wr_preg", rat_wr_preg, e.a);
          chk("free_preg", free_preg, e.b);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = dn_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("new_tail", new_tail, e.a);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic randomize_rob();
    for (int i = 0; i < N_ROB; i++) begin
      m_has[i]  = 1'($urandom);
      m_areg[i] = AW'($urandom);
      m_old[i]  = PW'($urandom);
      m_new[i]  = PW'($urandom);
    end
  endtask

  // Drive one backout pulse in the current cycle and record what should follow.
  task automatic issue(input logic [RW-1:0] r, input logic [RW-1:0] t);
    int c, n, idx;
    ev_t e;
    c = cyc;
    backout = 1; backout_rob = r; rob_tail = t;
    if (c >= busy_s && c <= busy_e) begin
      if (lost_cyc > c + 1) lost_cyc = c + 1;
    end else begin
      n = (int'(t) - int'(r) - 1 + N_ROB) % N_ROB;
      for (int i = 1; i <= n; i++) begin
        idx = (int'(t) - i + N_ROB) % N_ROB;
        e.cyc = c + i; e.areg = '0; e.a = PW'(idx); e.b = '0;
        rd_q.push_back(e);
        if (m_has[idx]) begin
          e.cyc = c + i + 2; e.areg = m_areg[idx]; e.a = m_old[idx]; e.b = m_new[idx];
          wr_q.push_back(e);
        end
      end
      e.cyc = c + n + ((n == 0) ? 1 : 3); e.areg = '0;
      e.a = PW'((int'(r) + 1) % N_ROB); e.b = '0;
      dn_q.push_back(e);
      busy_s = c + 1;
      busy_e = e.cyc;
    end
    step(1);
    backout = 0;
  endtask

  task automatic wait_idle();
    while (cyc <= busy_e) step(1);
  endtask

  initial begin
    randomize_rob();
    #2;
    chk("reset_rd_en", rob_rd_en, 0);
    chk("reset_rat_wr_en", rat_wr_en, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_new_tail", new_tail, 0);
    chk("reset_rd_addr", rob_rd_addr, 0);
    step(2);
    rst = 0;
    step(1);

    // Basic walk
    for (int i = 0; i < N_ROB; i++) m_has[i] = 1;
    issue(4'd3, 4'd7);
    wait_idle(); step(1);

    // Wrap
    randomize_rob();
    issue(4'd14, 4'd2);
    wait_idle(); step(1);

    // Empty
    issue(4'd5, 4'd6);
    wait_idle(); step(1);

    // Mixed
    for (int i = 0; i < N_ROB; i++) m_has[i] = 1;
    m_has[2] = 0;
    issue(4'd0, 4'd4);
    wait_idle(); step(1);

    // Full ROB (tail == branch) : fifteen entries
    randomize_rob();
    issue(4'd9, 4'd9);
    wait_idle(); step(1);

    // Collision in cycle 2 of a walk
    randomize_rob();
    issue(4'd3, 4'd7);
    step(1);
    issue(4'd1, 4'd12);
    wait_idle(); step(2);

    // Reset in cycle 2 of the basic walk
    randomize_rob();
    issue(4'd3, 4'd7);
    step(1);
    rst = 1;
    rd_q.delete(); wr_q.delete(); dn_q.delete();
    busy_s = 0; busy_e = -1; lost_cyc = NEVER;
    #1;
    chk("async_rst_rd_en", rob_rd_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_lost", backout_lost, 0);
    chk("async_rst_rat_wr_en", rat_wr_en, 0);
    chk("async_rst_rd_addr", rob_rd_addr, 0);
    @(posedge clk); #1;
    rst = 0;
    issue(4'd3, 4'd7);
    wait_idle(); step(1);

    // Random walks with random gaps and occasional colliding backouts
    for (int k = 0; k < 40; k++) begin
      wait_idle();
      randomize_rob();
      issue(RW'($urandom), RW'($urandom));
      for (int g = $urandom_range(0, 20); g > 0; g--) begin
        if ($urandom_range(0, 9) == 0) begin
          if (cyc > busy_e) randomize_rob();
          issue(RW'($urandom), RW'($urandom));
        end else step(1);
      end
    end
    wait_idle(); step(3);

    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("dn_q_empty", dn_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
